// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit control path: FSM state encoding and parity types.
// Optional macro UART_TX_TWO_STOP_EN adds the STOP2 state for two stop bits.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
`ifdef UART_TX_TWO_STOP_EN
        ,
        STOP2  = 3'd5
`endif
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Combinational parity generator: even parity sets the bit so the total count of ones is even.
module parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] p_data_i,
    input  logic                  par_typ_i,
    output logic                  par_bit_o
);

    assign par_bit_o = (par_typ_i == PAR_ODD) ? ~^p_data_i : ^p_data_i;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX framing FSM: start, serializer-driven data bits, optional parity, stop bit(s).
// Build option: define UART_TX_TWO_STOP_EN to emit two stop bits per frame.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_e state_q;
    tx_state_e state_d;
    logic      busy_q;
    logic      par_bit_q;
    logic      par_bit_d;
    logic      par_en_q;
    logic      par_en_d;
    logic      par_calc;

    parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .p_data_i (P_DATA),
        .par_typ_i(PAR_TYP),
        .par_bit_o(par_calc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= (state_d != IDLE);
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        TX_OUT    = 1'b1;
        ser_en    = 1'b0;
        case (state_q)
            IDLE: begin
                // Frame options are frozen here; later input changes cannot touch this frame.
                if (DATA_VALID) begin
                    par_en_d  = PAR_EN;
                    par_bit_d = par_calc;
                    state_d   = START;
                end
            end
            START: begin
                TX_OUT  = 1'b0;
                ser_en  = 1'b1;
                state_d = DATA;
            end
            DATA: begin
                TX_OUT = ser_data;
                ser_en = ~ser_done;
                if (ser_done) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                TX_OUT  = par_bit_q;
                state_d = STOP;
            end
            STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                state_d = STOP2;
`else
                state_d = IDLE;
`endif
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP2: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Busy = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with a frame-level reference model and a behavioural serializer.
module tb_uart_tx_ctrl;

    localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int XS = 1;
`else
    localparam int XS = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [DW-1:0] P_DATA = '0;
    logic          DATA_VALID = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          ser_data;
    logic          ser_done;
    logic          ser_en;
    logic          TX_OUT;
    logic          Busy;
    logic          force_done = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .ser_data  (ser_data),
        .ser_done  (ser_done),
        .ser_en    (ser_en),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    // Behavioural serializer: loads on accept, presents MSB first one bit per ser_en.
    logic [DW-1:0] sreg = '0;
    int            scnt = 0;
    logic          sbit = 1'b0;
    always @(posedge CLK) begin
        if (RST) begin
            scnt <= 0;
            sbit <= 1'b0;
        end else if (DATA_VALID && !Busy) begin
            sreg <= P_DATA;
            scnt <= 0;
        end else if (ser_en) begin
            sbit <= sreg[DW-1];
            sreg <= sreg << 1;
            scnt <= scnt + 1;
        end
    end
    assign ser_data = sbit;
    assign ser_done = force_done || (scnt == DW);

    // Frame model: a queue of expected {TX_OUT, Busy, ser_en}, one entry per line cycle.
    logic [2:0] mq[$];
    always @(posedge CLK) begin
        int   nd;
        logic par;
        if (RST) begin
            mq.delete();
        end else if (mq.size() != 0) begin
            void'(mq.pop_front());
        end else if (DATA_VALID) begin
            nd  = force_done ? 1 : DW;
            par = ((($countones(P_DATA) % 2) == 1) ? 1'b1 : 1'b0) ^ PAR_TYP;
            mq.push_back(3'b010 | 3'b001);
            for (int i = 0; i < nd; i++) begin
                mq.push_back({P_DATA[DW-1-i], 1'b1, (i < nd - 1)});
            end
            if (PAR_EN) mq.push_back({par, 2'b10});
            for (int i = 0; i < 1 + XS; i++) mq.push_back(3'b110);
        end
    end

    always @(negedge CLK) begin
        logic [2:0] exp_v;
        logic [2:0] got_v;
        if (chk_en) begin
            exp_v = (mq.size() == 0) ? 3'b100 : mq[0];
            got_v = {TX_OUT, Busy, ser_en};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_bad++;
                $display("FAIL cycle_model t=%0t tx/busy/sen got=%b required=%b", $time, got_v, exp_v);
            end
        end
    end

    // Line history, newest sample in bit 0.
    logic [63:0] tx_h = '0;
    logic [63:0] bz_h = '0;
    logic [63:0] se_h = '0;
    always @(negedge CLK) begin
        tx_h = {tx_h[62:0], TX_OUT};
        bz_h = {bz_h[62:0], Busy};
        se_h = {se_h[62:0], ser_en};
    end

    function automatic int ones_last(input logic [63:0] h, input int w);
        int c;
        c = 0;
        for (int i = 0; i < w; i++) c += int'(h[i]);
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s got=%h required=%h", name, got, exp_v);
        end
    endtask

    task automatic wait_samples(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic send_pulse(input logic [DW-1:0] d, input logic pe, input logic pt);
        @(posedge CLK); #2;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        @(posedge CLK); #2;
        DATA_VALID = 1'b0;
    endtask

    initial begin
        int L;
        @(posedge CLK); #2;
        chk_en = 1'b1;
        @(posedge CLK); #2;
        RST = 1'b0;
        wait_samples(1);
        check("reset_state", {29'd0, tx_h[0], bz_h[0], se_h[0]}, 32'b100);
        $display("txn reset done");

        // Plain frame, no parity
        send_pulse(8'hA5, 1'b0, 1'b0);
        wait_samples(11);
        check("a5_noparity_bits", {21'd0, tx_h[10:0]}, {21'd0, 1'b0, 8'hA5, 2'b11});
        check("a5_noparity_busy", ones_last(bz_h, 11), 10 + XS);
        check("a5_noparity_seren", ones_last(se_h, 11), 8);
        $display("txn A5 no-parity frame");

        // Even then odd parity on A5
        send_pulse(8'hA5, 1'b1, 1'b0);
        wait_samples(12);
        check("a5_even_bits", {20'd0, tx_h[11:0]}, {20'd0, 1'b0, 8'hA5, 3'b011});
        check("a5_even_busy", ones_last(bz_h, 12), 11 + XS);
        $display("txn A5 even-parity frame");
        send_pulse(8'hA5, 1'b1, 1'b1);
        wait_samples(12);
        check("a5_odd_bits", {20'd0, tx_h[11:0]}, {20'd0, 1'b0, 8'hA5, 3'b111});
        check("a5_odd_busy", ones_last(bz_h, 12), 11 + XS);
        $display("txn A5 odd-parity frame");

        // DATA_VALID held high: back-to-back frames with a single idle gap
        L = 11 + XS;
        @(posedge CLK); #2;
        P_DATA = 8'h07; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        @(posedge CLK); #2;
        wait_samples(2 * L + 1);
        DATA_VALID = 1'b0;
        check("b2b_first_bits", {21'd0, tx_h[2*L -: 11]}, {21'd0, 1'b0, 8'h07, 2'b11});
        check("b2b_gap_busy", {31'd0, bz_h[L]}, 32'd0);
        check("b2b_gap_tx", {31'd0, tx_h[L]}, 32'd1);
        check("b2b_second_start", {31'd0, tx_h[L-1]}, 32'd0);
        check("b2b_busy_total", ones_last(bz_h, 2 * L + 1), 2 * L);
        $display("txn 07 back-to-back frames");
        wait_samples(3);

        // Request mid-frame is dropped and cannot alter the frame
        send_pulse(8'hA5, 1'b1, 1'b0);
        wait_samples(3);
        @(posedge CLK); #2;
        DATA_VALID = 1'b1; P_DATA = 8'hFF; PAR_TYP = 1'b1;
        @(posedge CLK); #2;
        DATA_VALID = 1'b0; P_DATA = 8'hA5; PAR_TYP = 1'b0;
        wait_samples(L - 3);
        check("midframe_bits", {20'd0, tx_h[L -: 12]}, {20'd0, 1'b0, 8'hA5, 3'b011});
        check("midframe_busy", ones_last(bz_h, L + 1), L);
        check("midframe_idle_after", {31'd0, bz_h[0]}, 32'd0);
        wait_samples(3);
        check("midframe_no_requeue", {29'd0, bz_h[2:0]}, 32'd0);
        $display("txn mid-frame request ignored");

        // Reset during DATA abandons the frame
        send_pulse(8'h3C, 1'b0, 1'b0);
        wait_samples(3);
        @(posedge CLK); #2;
        RST = 1'b1;
        @(posedge CLK); #2;
        RST = 1'b0;
        wait_samples(1);
        check("midreset_outputs", {29'd0, tx_h[0], bz_h[0], se_h[0]}, 32'b100);
        send_pulse(8'h3C, 1'b0, 1'b0);
        wait_samples(11);
        check("post_reset_bits", {21'd0, tx_h[10:0]}, {21'd0, 1'b0, 8'h3C, 2'b11});
        check("post_reset_busy", ones_last(bz_h, 11), 10 + XS);
        $display("txn 3C after mid-frame reset");

        // 55 with even parity: stop bit(s) close the frame
        send_pulse(8'h55, 1'b1, 1'b0);
        wait_samples(12 + XS);
        check("s55_bits", {20'd0, tx_h[11+XS -: 12]}, {20'd0, 1'b0, 8'h55, 3'b011});
        check("s55_busy", ones_last(bz_h, 12 + XS), 11 + XS);
        check("s55_last_high", {31'd0, tx_h[0]}, 32'd1);
        $display("txn 55 even-parity frame");

        // Serializer already done on DATA entry: one DATA cycle, no lockup
        @(posedge CLK); #2;
        force_done = 1'b1;
        send_pulse(8'hA5, 1'b0, 1'b0);
        wait_samples(4);
        force_done = 1'b0;
        check("fault_bits", {28'd0, tx_h[3:0]}, 32'b0111);
        check("fault_busy", ones_last(bz_h, 4), 3 + XS);
        check("fault_seren", ones_last(se_h, 4), 1);
        wait_samples(3);
        check("fault_idle_after", {29'd0, bz_h[2:0]}, 32'd0);
        $display("txn early ser_done frame");

        wait_samples(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
